// File: rtl/dff_shift_bank.sv
// dff_shift_bank: WIDTH-bit edge-triggered register bank with hold, shift right,
// shift left and parallel load. It counts the shifts made since the last load or
// reset, saturating at WIDTH, and raises empty once every loaded bit has left.
//
// Optional feature: define DFF_SHIFT_ROTATE_EN to add the rot input. While rot=1,
// shifts become rotates that ignore the serial inputs and leave cnt alone.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset; loads q=RESET_VAL and cnt=WIDTH
//   en      clock enable; 0 holds q and cnt
//   mode    00 hold, 01 shift right, 10 shift left, 11 parallel load
//   d       parallel load data
//   sin_r   serial in, enters q[WIDTH-1] on a shift right
//   sin_l   serial in, enters q[0] on a shift left
//   rot     (DFF_SHIFT_ROTATE_EN only) turns shifts into rotates
//   q       register contents
//   qbar    bitwise complement of q
//   sout_r  q[0], the bit leaving on a shift right
//   sout_l  q[WIDTH-1], the bit leaving on a shift left
//   cnt     shifts since the last load or reset, saturating at WIDTH
//   empty   1 when cnt == WIDTH
module dff_shift_bank #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int unsigned      CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
`ifdef DFF_SHIFT_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             empty
);

  localparam logic [1:0]    MODE_HOLD = 2'b00;
  localparam logic [1:0]    MODE_SHR  = 2'b01;
  localparam logic [1:0]    MODE_SHL  = 2'b10;
  localparam logic [1:0]    MODE_LOAD = 2'b11;
  localparam logic [CW-1:0] CNT_FULL  = CW'(WIDTH);

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [CW-1:0]    cnt_sat;
  logic             shift_in_r;
  logic             shift_in_l;
  logic             shift_counts;

  // Serial feed selection: a rotate recirculates the outgoing bit and leaves cnt alone.
`ifdef DFF_SHIFT_ROTATE_EN
  assign shift_in_r   = rot ? q[0] : sin_r;
  assign shift_in_l   = rot ? q[WIDTH-1] : sin_l;
  assign shift_counts = ~rot;
`else
  assign shift_in_r   = sin_r;
  assign shift_in_l   = sin_l;
  assign shift_counts = 1'b1;
`endif

  // The counter stops at WIDTH and never wraps; data keeps moving after that.
  assign cnt_sat = (cnt == CNT_FULL) ? cnt : cnt + CW'(1);

  // Next-state decode. An X or hold mode falls through to the defaults, so q and cnt hold.
  always_comb begin
    q_nxt   = q;
    cnt_nxt = cnt;
    if (en) begin
      case (mode)
        MODE_SHR: begin
          q_nxt = {shift_in_r, q[WIDTH-1:1]};
          if (shift_counts) cnt_nxt = cnt_sat;
        end
        MODE_SHL: begin
          q_nxt = {q[WIDTH-2:0], shift_in_l};
          if (shift_counts) cnt_nxt = cnt_sat;
        end
        MODE_LOAD: begin
          q_nxt   = d;
          cnt_nxt = '0;
        end
        MODE_HOLD: begin
          q_nxt   = q;
          cnt_nxt = cnt;
        end
        default: begin
          q_nxt   = q;
          cnt_nxt = cnt;
        end
      endcase
    end
  end

  // State register. Reset leaves the bank "empty", as if everything was already shifted out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q   <= RESET_VAL;
      cnt <= CNT_FULL;
    end else begin
      q   <= q_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Derived outputs, decoded straight from the registered state.
  assign qbar   = ~q;
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];
  assign empty  = (cnt == CNT_FULL);

endmodule
